// File: rtl/processor_pkg.sv
// Shared types and constants for the multi-cycle controller: opcodes, FSM states,
// ALU select codes and instruction field positions.
package processor_pkg;

    localparam int PC_WIDTH       = 7;
    localparam int D_ADDR_WIDTH   = 8;
    localparam int REG_ADDR_WIDTH = 4;
    localparam int IR_WIDTH       = 16;

    // Instruction field positions (op=[15:12], Ra=[11:8], Rb=[7:4], Rw=[3:0])
    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int RA_HI = 11;
    localparam int RA_LO = 8;
    localparam int RB_HI = 7;
    localparam int RB_LO = 4;
    localparam int RW_HI = 3;
    localparam int RW_LO = 0;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'h0,
        OP_STORE = 4'h1,
        OP_LOAD  = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_HALT  = 4'h5
    } opcode_t;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD_A = 4'd3,
        S_LOAD_B = 4'd4,
        S_STORE  = 4'd5,
        S_ADD    = 4'd6,
        S_SUB    = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/program_counter.sv
// Instruction ROM address counter: clears on reset, advances by one (wrapping) when Inc is high.
module program_counter
    import processor_pkg::*;
#(
    parameter int PC_WIDTH = processor_pkg::PC_WIDTH
) (
    input  logic                Clk,
    input  logic                Reset_N,
    input  logic                Inc,
    output logic [PC_WIDTH-1:0] PC
);

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            PC <= '0;
        end else if (Inc) begin
            PC <= PC + 1'b1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle controller: holds IR, sequences fetch/decode/execute and produces every
// register-file, data-RAM and ALU control for the datapath.
module control_unit
    import processor_pkg::*;
#(
    parameter int PC_WIDTH       = processor_pkg::PC_WIDTH,
    parameter int D_ADDR_WIDTH   = processor_pkg::D_ADDR_WIDTH,
    parameter int REG_ADDR_WIDTH = processor_pkg::REG_ADDR_WIDTH,
    parameter int IR_WIDTH       = processor_pkg::IR_WIDTH
) (
    input  logic                      Clk,
    input  logic                      Reset_N,
    input  logic [IR_WIDTH-1:0]       IR_In,
    output logic [PC_WIDTH-1:0]       PC_Addr,
    output logic [D_ADDR_WIDTH-1:0]   D_Addr,
    output logic                      D_Rd,
    output logic                      D_Wr,
    output logic                      RF_Sel,
    output logic [REG_ADDR_WIDTH-1:0] RF_W_Addr,
    output logic                      RF_W_En,
    output logic [REG_ADDR_WIDTH-1:0] RF_Ra_Addr,
    output logic [REG_ADDR_WIDTH-1:0] RF_Rb_Addr,
    output logic [2:0]                ALU_Sel,
    output logic                      Halted,
    output logic [3:0]                State_Out
);

    state_t                state;
    state_t                next_state;
    logic [IR_WIDTH-1:0]   ir;
    opcode_t               opcode;
    logic                  pc_inc;

    assign opcode = opcode_t'(ir[OP_HI:OP_LO]);
    assign pc_inc = (state == S_FETCH);

    program_counter #(
        .PC_WIDTH(PC_WIDTH)
    ) u_pc (
        .Clk    (Clk),
        .Reset_N(Reset_N),
        .Inc    (pc_inc),
        .PC     (PC_Addr)
    );

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state <= S_INIT;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == S_FETCH) begin
                ir <= IR_In;
            end
        end
    end

    // Opcodes 0110-1111 fall into the default arm and behave as NOOP.
    always_comb begin
        next_state = state;
        case (state)
            S_INIT:   next_state = S_FETCH;
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD:  next_state = S_LOAD_A;
                    OP_STORE: next_state = S_STORE;
                    OP_ADD:   next_state = S_ADD;
                    OP_SUB:   next_state = S_SUB;
                    OP_HALT:  next_state = S_HALT;
                    default:  next_state = S_FETCH;
                endcase
            end
            S_LOAD_A: next_state = S_LOAD_B;
            S_LOAD_B: next_state = S_FETCH;
            S_STORE:  next_state = S_FETCH;
            S_ADD:    next_state = S_FETCH;
            S_SUB:    next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_INIT;
        endcase
    end

    // Address fields follow IR at all times; only the strobes below qualify them.
    always_comb begin
        D_Addr     = (opcode == OP_LOAD) ? ir[RA_HI:RB_LO] : ir[RB_HI:RW_LO];
        RF_Ra_Addr = ir[RA_HI:RA_LO];
        RF_Rb_Addr = ir[RB_HI:RB_LO];
        RF_W_Addr  = ir[RW_HI:RW_LO];
        D_Rd       = 1'b0;
        D_Wr       = 1'b0;
        RF_Sel     = 1'b0;
        RF_W_En    = 1'b0;
        ALU_Sel    = ALU_PASS;
        Halted     = 1'b0;
        case (state)
            S_LOAD_A: D_Rd = 1'b1;
            S_LOAD_B: begin
                D_Rd    = 1'b1;
                RF_Sel  = 1'b1;
                RF_W_En = 1'b1;
            end
            S_STORE:  D_Wr = 1'b1;
            S_ADD: begin
                ALU_Sel = ALU_ADD;
                RF_W_En = 1'b1;
            end
            S_SUB: begin
                ALU_Sel = ALU_SUB;
                RF_W_En = 1'b1;
            end
            S_HALT:   Halted = 1'b1;
            default:  ;
        endcase
    end

    assign State_Out = state;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: an instruction-level model expands each ROM word
// into its expected per-cycle outputs, compared every cycle, plus literal pin checks.
module tb_control_unit;

    logic        Clk;
    logic        Reset_N;
    logic [15:0] IR_In;
    logic [6:0]  PC_Addr;
    logic [7:0]  D_Addr;
    logic        D_Rd;
    logic        D_Wr;
    logic        RF_Sel;
    logic [3:0]  RF_W_Addr;
    logic        RF_W_En;
    logic [3:0]  RF_Ra_Addr;
    logic [3:0]  RF_Rb_Addr;
    logic [2:0]  ALU_Sel;
    logic        Halted;
    logic [3:0]  State_Out;

    logic [15:0] rom [128];

    typedef struct {
        int pc;
        bit d_rd;
        bit d_wr;
        bit w_en;
        bit rf_sel;
        bit halted;
        int alu;
        int d_addr;
        int ra;
        int rb;
        int wa;
        bit chk_ra;
        bit chk_rb;
        bit chk_alu;
    } exp_t;

    exp_t exp_q[$];
    bit   chk_en;
    int   assert_count;
    int   fail_count;

    control_unit dut (
        .Clk       (Clk),
        .Reset_N   (Reset_N),
        .IR_In     (IR_In),
        .PC_Addr   (PC_Addr),
        .D_Addr    (D_Addr),
        .D_Rd      (D_Rd),
        .D_Wr      (D_Wr),
        .RF_Sel    (RF_Sel),
        .RF_W_Addr (RF_W_Addr),
        .RF_W_En   (RF_W_En),
        .RF_Ra_Addr(RF_Ra_Addr),
        .RF_Rb_Addr(RF_Rb_Addr),
        .ALU_Sel   (ALU_Sel),
        .Halted    (Halted),
        .State_Out (State_Out)
    );

    assign IR_In = rom[PC_Addr];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic exp_t idle_rec(input int pc);
        exp_t r;
        r.pc = pc;
        r.d_rd = 0;
        r.d_wr = 0;
        r.w_en = 0;
        r.rf_sel = 0;
        r.halted = 0;
        r.alu = 0;
        r.d_addr = 0;
        r.ra = 0;
        r.rb = 0;
        r.wa = 0;
        r.chk_ra = 0;
        r.chk_rb = 0;
        r.chk_alu = 0;
        return r;
    endfunction

    // Instruction-level model: each ROM word becomes FETCH, DECODE and its execute cycles.
    task automatic build_model(input int ncycles);
        int          pc;
        logic [15:0] ir;
        exp_t        r;
        exp_q.delete();
        pc = 0;
        exp_q.push_back(idle_rec(0));
        while (exp_q.size() < ncycles) begin
            exp_q.push_back(idle_rec(pc));
            ir = rom[pc];
            pc = (pc + 1) % 128;
            exp_q.push_back(idle_rec(pc));
            r = idle_rec(pc);
            case (ir[15:12])
                4'h1: begin
                    r.d_wr = 1;
                    r.d_addr = int'(ir[7:0]);
                    r.ra = int'(ir[11:8]);
                    r.chk_ra = 1;
                    exp_q.push_back(r);
                end
                4'h2: begin
                    r.d_rd = 1;
                    r.d_addr = int'(ir[11:4]);
                    exp_q.push_back(r);
                    r.w_en = 1;
                    r.rf_sel = 1;
                    r.wa = int'(ir[3:0]);
                    exp_q.push_back(r);
                end
                4'h3, 4'h4: begin
                    r.w_en = 1;
                    r.alu = (ir[15:12] == 4'h3) ? 1 : 2;
                    r.chk_alu = 1;
                    r.ra = int'(ir[11:8]);
                    r.rb = int'(ir[7:4]);
                    r.wa = int'(ir[3:0]);
                    r.chk_ra = 1;
                    r.chk_rb = 1;
                    exp_q.push_back(r);
                end
                4'h5: begin
                    r.halted = 1;
                    while (exp_q.size() < ncycles) exp_q.push_back(r);
                end
                default: ;
            endcase
        end
        while (exp_q.size() > ncycles) void'(exp_q.pop_back());
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            if (exp_q.size() == 0) begin
                assert_count++;
                fail_count++;
                $display("[TB] FAIL model_underrun: got empty queue, expected an entry");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("pc", int'(PC_Addr), e.pc);
                checkOutput("d_rd", int'(D_Rd), int'(e.d_rd));
                checkOutput("d_wr", int'(D_Wr), int'(e.d_wr));
                checkOutput("rf_w_en", int'(RF_W_En), int'(e.w_en));
                checkOutput("halted", int'(Halted), int'(e.halted));
                if (e.w_en) begin
                    checkOutput("rf_sel", int'(RF_Sel), int'(e.rf_sel));
                    checkOutput("rf_w_addr", int'(RF_W_Addr), e.wa);
                end
                if (e.chk_alu) checkOutput("alu_sel", int'(ALU_Sel), e.alu);
                if (e.d_rd || e.d_wr) checkOutput("d_addr", int'(D_Addr), e.d_addr);
                if (e.chk_ra) checkOutput("ra_addr", int'(RF_Ra_Addr), e.ra);
                if (e.chk_rb) checkOutput("rb_addr", int'(RF_Rb_Addr), e.rb);
            end
        end
    end

    task automatic release_reset();
        Reset_N = 1'b0;
        repeat (2) @(posedge Clk);
        #2 Reset_N = 1'b1;
    endtask

    // Hand-computed expectations tied to the directed programs (mode 1: directed, 2: wrap).
    task automatic pin_checks(input int mode, input int i);
        if (mode == 1) begin
            case (i)
                3: begin
                    checkOutput("pin_load_a_daddr", int'(D_Addr), 'h1B);
                    checkOutput("pin_load_a_drd", int'(D_Rd), 1);
                end
                4: begin
                    checkOutput("pin_load_b_wen", int'(RF_W_En), 1);
                    checkOutput("pin_load_b_sel", int'(RF_Sel), 1);
                    checkOutput("pin_load_b_waddr", int'(RF_W_Addr), 3);
                end
                7: begin
                    checkOutput("pin_add_ra", int'(RF_Ra_Addr), 3);
                    checkOutput("pin_add_rb", int'(RF_Rb_Addr), 4);
                    checkOutput("pin_add_waddr", int'(RF_W_Addr), 5);
                    checkOutput("pin_add_alu", int'(ALU_Sel), 1);
                    checkOutput("pin_add_sel", int'(RF_Sel), 0);
                end
                8: checkOutput("pin_add_one_cycle", int'(RF_W_En), 0);
                10: begin
                    checkOutput("pin_store_dwr", int'(D_Wr), 1);
                    checkOutput("pin_store_daddr", int'(D_Addr), 'h80);
                    checkOutput("pin_store_ra", int'(RF_Ra_Addr), 5);
                    checkOutput("pin_store_wen", int'(RF_W_En), 0);
                end
                13: checkOutput("pin_undef_pc", int'(PC_Addr), 4);
                default: begin
                    if (i >= 15) begin
                        checkOutput("pin_halt_flag", int'(Halted), 1);
                        checkOutput("pin_halt_pc", int'(PC_Addr), 5);
                    end
                end
            endcase
        end else if (mode == 2) begin
            if (i == 255) checkOutput("pin_pc_127", int'(PC_Addr), 127);
            if (i == 257) checkOutput("pin_pc_wrap", int'(PC_Addr), 0);
        end
    endtask

    task automatic applyStimulus(input int ncycles, input int mode);
        build_model(ncycles);
        release_reset();
        chk_en = 1'b1;
        for (int i = 0; i < ncycles; i++) begin
            @(negedge Clk);
            pin_checks(mode, i);
        end
        #1 chk_en = 1'b0;
        if (exp_q.size() != 0) begin
            assert_count++;
            fail_count++;
            $display("[TB] FAIL model_leftover: got %0d entries left, expected 0", exp_q.size());
        end
    endtask

    task automatic load_directed();
        for (int a = 0; a < 128; a++) rom[a] = 16'h0000;
        rom[0] = 16'h21B3;
        rom[1] = 16'h3345;
        rom[2] = 16'h1580;
        rom[3] = 16'hF000;
        rom[4] = 16'h5000;
    endtask

    task automatic load_random();
        logic [15:0] w;
        logic [3:0]  op;
        for (int a = 0; a < 128; a++) begin
            w  = 16'($urandom());
            op = 4'($urandom_range(0, 15));
            if (op == 4'h5 && $urandom_range(0, 9) != 0) op = 4'h3;
            w[15:12] = op;
            rom[a] = w;
        end
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        chk_en       = 1'b0;
        Reset_N      = 1'b1;
        load_directed();
        #1 Reset_N = 1'b0;
        #2;
        checkOutput("rst_pc", int'(PC_Addr), 0);
        checkOutput("rst_drd", int'(D_Rd), 0);
        checkOutput("rst_dwr", int'(D_Wr), 0);
        checkOutput("rst_wen", int'(RF_W_En), 0);
        checkOutput("rst_alu", int'(ALU_Sel), 0);
        checkOutput("rst_sel", int'(RF_Sel), 0);
        checkOutput("rst_halted", int'(Halted), 0);

        // Reset asserted in the middle of the ADD execute cycle.
        release_reset();
        for (int i = 0; i < 8; i++) @(negedge Clk);
        checkOutput("mid_add_wen_before", int'(RF_W_En), 1);
        #1 Reset_N = 1'b0;
        #1;
        checkOutput("mid_add_wen_after", int'(RF_W_En), 0);
        checkOutput("mid_add_alu_after", int'(ALU_Sel), 0);
        checkOutput("mid_add_pc_after", int'(PC_Addr), 0);

        applyStimulus(36, 1);

        for (int a = 0; a < 128; a++) rom[a] = 16'h0000;
        applyStimulus(260, 2);

        for (int p = 0; p < 8; p++) begin
            load_random();
            applyStimulus(200, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
